// File: rtl/lcd_write_scheduler_pkg.sv
// Shared types and LCD command constants for the write scheduler.
// Chip-select pairs are packed as {cs2, cs1} throughout.
package lcd_write_scheduler_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        INIT_ON,
        INIT_LINE,
        IDLE,
        SET_PAGE,
        SET_COL,
        WR_DATA
    } state_e;

    localparam logic [7:0] CMD_ON   = 8'h3F;
    localparam logic [7:0] CMD_LINE = 8'hC0;
    localparam logic [7:0] CMD_PAGE = 8'hB8;
    localparam logic [7:0] CMD_Y    = 8'h40;

    // Column bit 6 picks the half of the panel: 0 -> cs1, 1 -> cs2.
    function automatic logic [1:0] chip_cs(input logic chip);
        return chip ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lcd_write_scheduler_bus.sv
// One LCD bus transaction: setup cycle, EN_CYC cycles strobe high, EN_CYC cycles hold.
// data/di/cs are captured on start and stay stable for the whole transaction.
module lcd_bus_cycle #(
    parameter int EN_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       di,
    input  logic [1:0] cs,
    output logic [7:0] lcd_data,
    output logic       lcd_en,
    output logic       lcd_di,
    output logic       lcd_cs1,
    output logic       lcd_cs2,
    output logic       active,
    output logic       done
);

    localparam int LAST = 2 * EN_CYC;
    localparam int CW   = $clog2(LAST + 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          di_q, di_d;
    logic [1:0]    cs_q, cs_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        di_d     = di_q;
        cs_d     = cs_q;
        done     = active_q && (cnt_q == CW'(LAST));
        if (start && !active_q) begin
            active_d = 1'b1;
            cnt_d    = '0;
            data_d   = data;
            di_d     = di;
            cs_d     = cs;
        end else if (active_q) begin
            if (done) begin
                active_d = 1'b0;
                cnt_d    = '0;
                cs_d     = 2'b00;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            di_q     <= 1'b0;
            cs_q     <= 2'b00;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            di_q     <= di_d;
            cs_q     <= cs_d;
        end
    end

    // Count 0 is the setup cycle; strobe covers counts 1..EN_CYC.
    assign lcd_en   = active_q && (cnt_q != '0) && (cnt_q <= CW'(EN_CYC));
    assign lcd_data = data_q;
    assign lcd_di   = di_q;
    assign lcd_cs1  = cs_q[0];
    assign lcd_cs2  = cs_q[1];
    assign active   = active_q;

endmodule

// File: rtl/lcd_write_scheduler.sv
// Two-requester pixel-byte write scheduler for a dual-chip 128x64 LCD.
// Runs the panel reset/init, then round-robin grants writes, skipping address commands on cache hits.
module lcd_write_scheduler
    import lcd_write_scheduler_pkg::*;
#(
    parameter int EN_CYC  = 4,
    parameter int RST_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_page,
    input  logic [6:0] req0_col,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_page,
    input  logic [6:0] req1_col,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_di,
    output logic       lcd_rstn,
    output logic       lcd_cs1,
    output logic       lcd_cs2
);

    localparam int RCW = $clog2(2 * RST_CYC + 1);

    state_e         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [2:0]     page_q, page_d;
    logic [6:0]     col_q, col_d;
    logic [7:0]     data_q, data_d;
    logic           cache_vld_q, cache_vld_d;
    logic           cache_chip_q, cache_chip_d;
    logic [2:0]     cache_page_q, cache_page_d;
    logic [5:0]     cache_y_q, cache_y_d;

    logic       bus_start, bus_active, bus_done;
    logic [7:0] cmd_data;
    logic       cmd_di;
    logic [1:0] cmd_cs;

    logic       grant0, grant1;
    logic [2:0] w_page;
    logic [6:0] w_col;
    logic [7:0] w_data;
    logic       cache_hit;

    // Pointer names the requester that wins a tie.
    assign grant0 = req0_valid && (!req1_valid || !ptr_q);
    assign grant1 = req1_valid && !grant0;
    assign w_page = grant1 ? req1_page : req0_page;
    assign w_col  = grant1 ? req1_col  : req0_col;
    assign w_data = grant1 ? req1_data : req0_data;
    assign cache_hit = cache_vld_q && (cache_chip_q == w_col[6]) &&
                       (cache_page_q == w_page) && (cache_y_q == w_col[5:0]);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rst_cnt_d    = rst_cnt_q;
        page_d       = page_q;
        col_d        = col_q;
        data_d       = data_q;
        cache_vld_d  = cache_vld_q;
        cache_chip_d = cache_chip_q;
        cache_page_d = cache_page_q;
        cache_y_d    = cache_y_q;
        bus_start    = 1'b0;
        cmd_data     = 8'h00;
        cmd_di       = 1'b0;
        cmd_cs       = 2'b00;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        unique case (state_q)
            RST_HOLD: begin
                if (rst_cnt_q == RCW'(2 * RST_CYC - 1)) begin
                    rst_cnt_d = '0;
                    state_d   = INIT_ON;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            INIT_ON: begin
                bus_start = !bus_active;
                cmd_data  = CMD_ON;
                cmd_cs    = 2'b11;
                if (bus_done) state_d = INIT_LINE;
            end
            INIT_LINE: begin
                bus_start = !bus_active;
                cmd_data  = CMD_LINE;
                cmd_cs    = 2'b11;
                if (bus_done) state_d = IDLE;
            end
            IDLE: begin
                if (grant0 || grant1) begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                    ptr_d      = grant0;
                    page_d     = w_page;
                    col_d      = w_col;
                    data_d     = w_data;
                    state_d    = cache_hit ? WR_DATA : SET_PAGE;
                end
            end
            SET_PAGE: begin
                bus_start = !bus_active;
                cmd_data  = CMD_PAGE | {5'b0, page_q};
                cmd_cs    = chip_cs(col_q[6]);
                if (bus_done) state_d = SET_COL;
            end
            SET_COL: begin
                bus_start = !bus_active;
                cmd_data  = CMD_Y | {2'b0, col_q[5:0]};
                cmd_cs    = chip_cs(col_q[6]);
                if (bus_done) state_d = WR_DATA;
            end
            WR_DATA: begin
                bus_start = !bus_active;
                cmd_data  = data_q;
                cmd_di    = 1'b1;
                cmd_cs    = chip_cs(col_q[6]);
                if (bus_done) begin
                    // Panel auto-increments Y after a data write, wrapping within 64 columns.
                    cache_vld_d  = 1'b1;
                    cache_chip_d = col_q[6];
                    cache_page_d = page_q;
                    cache_y_d    = col_q[5:0] + 6'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = RST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_HOLD;
            ptr_q        <= 1'b0;
            rst_cnt_q    <= '0;
            page_q       <= '0;
            col_q        <= '0;
            data_q       <= '0;
            cache_vld_q  <= 1'b0;
            cache_chip_q <= 1'b0;
            cache_page_q <= '0;
            cache_y_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rst_cnt_q    <= rst_cnt_d;
            page_q       <= page_d;
            col_q        <= col_d;
            data_q       <= data_d;
            cache_vld_q  <= cache_vld_d;
            cache_chip_q <= cache_chip_d;
            cache_page_q <= cache_page_d;
            cache_y_q    <= cache_y_d;
        end
    end

    lcd_bus_cycle #(.EN_CYC(EN_CYC)) u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (bus_start),
        .data     (cmd_data),
        .di       (cmd_di),
        .cs       (cmd_cs),
        .lcd_data (lcd_data),
        .lcd_en   (lcd_en),
        .lcd_di   (lcd_di),
        .lcd_cs1  (lcd_cs1),
        .lcd_cs2  (lcd_cs2),
        .active   (bus_active),
        .done     (bus_done)
    );

    assign busy     = (state_q != IDLE);
    assign lcd_rw   = 1'b0;
    assign lcd_rstn = !((state_q == RST_HOLD) && (rst_cnt_q < RCW'(RST_CYC)));

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed bench for lcd_write_scheduler: a transaction-level model predicts bus traffic and grants,
// and literal expectations pin the key sequences.
module tb_lcd_write_scheduler;

    localparam int EN_CYC  = 4;
    localparam int RST_CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_page, req1_page;
    logic [6:0] req0_col, req1_col;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, busy;
    logic [7:0] lcd_data;
    logic       lcd_en, lcd_rw, lcd_di, lcd_rstn, lcd_cs1, lcd_cs2;

    lcd_write_scheduler #(.EN_CYC(EN_CYC), .RST_CYC(RST_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_page(req0_page), .req0_col(req0_col),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_page(req1_page), .req1_col(req1_col),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .busy(busy), .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rw(lcd_rw),
        .lcd_di(lcd_di), .lcd_rstn(lcd_rstn), .lcd_cs1(lcd_cs1), .lcd_cs2(lcd_cs2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] page;
        logic [6:0] col;
        logic [7:0] data;
    } wr_t;

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Transactions are {data, di, cs2, cs1}.
    wr_t         q0[$], q1[$];
    logic [10:0] exp_q[$];
    logic [10:0] obs[$];
    int          grants[$];
    logic        took0 = 1'b0, took1 = 1'b0;

    // Requester drivers: present queue head, pop it after a handshake.
    initial begin
        req0_valid = 1'b0; req0_page = '0; req0_col = '0; req0_data = '0;
        forever begin
            @(posedge clk); #1;
            if (took0 && q0.size() > 0) q0.delete(0);
            if (q0.size() > 0) begin
                req0_valid = 1'b1;
                {req0_page, req0_col, req0_data} = q0[0];
            end else req0_valid = 1'b0;
        end
    end

    initial begin
        req1_valid = 1'b0; req1_page = '0; req1_col = '0; req1_data = '0;
        forever begin
            @(posedge clk); #1;
            if (took1 && q1.size() > 0) q1.delete(0);
            if (q1.size() > 0) begin
                req1_valid = 1'b1;
                {req1_page, req1_col, req1_data} = q1[0];
            end else req1_valid = 1'b0;
        end
    end

    // Behavioural model state.
    bit          mptr, mvld, mchip, need_init;
    logic [2:0]  mpage;
    logic [5:0]  my;
    int          rstn_low, r0_cnt, idle_len, last_idle_len;
    logic        pen;
    logic [10:0] psnap, cur_txn, snap;
    int          en_len, hold_left;
    logic        e0, e1;
    wr_t         w;

    task automatic model_write(input wr_t wr);
        logic [1:0] cs;
        bit hit;
        cs  = (wr.col >= 7'd64) ? 2'b10 : 2'b01;
        hit = mvld && (mchip == (wr.col >= 7'd64)) && (mpage == wr.page) && (my == 6'(wr.col % 64));
        if (!hit) begin
            exp_q.push_back({8'hB8 + {5'b0, wr.page}, 1'b0, cs});
            exp_q.push_back({8'h40 + {2'b0, 6'(wr.col % 64)}, 1'b0, cs});
        end
        exp_q.push_back({wr.data, 1'b1, cs});
        mvld  = 1'b1;
        mchip = (wr.col >= 7'd64);
        mpage = wr.page;
        my    = 6'((int'(wr.col) % 64 + 1) % 64);
    endtask

    always @(negedge clk) begin
        snap  = {lcd_data, lcd_di, lcd_cs2, lcd_cs1};
        took0 = req0_valid && req0_ready;
        took1 = req1_valid && req1_ready;
        if (!rst_n) begin
            exp_q.delete();
            mptr = 0; mvld = 0; need_init = 1;
            pen = 0; hold_left = 0; rstn_low = 0; idle_len = 0;
        end else begin
            if (need_init) begin
                exp_q.push_back({8'h3F, 1'b0, 2'b11});
                exp_q.push_back({8'hC0, 1'b0, 2'b11});
                need_init = 0;
            end
            if (!lcd_rstn) rstn_low++;
            if (req0_ready) r0_cnt++;
            chk("rw_low", 32'(lcd_rw), 0);
            if (!busy) begin
                e0 = req0_valid && (!req1_valid || mptr == 0);
                e1 = req1_valid && (!req0_valid || mptr == 1);
                chk("ready0", 32'(req0_ready), 32'(e0));
                chk("ready1", 32'(req1_ready), 32'(e1));
                chk("idle_cs", 32'({lcd_cs2, lcd_cs1}), 0);
                chk("idle_drained", exp_q.size(), 0);
                idle_len++;
                if (e0 || e1) begin
                    w = e0 ? wr_t'({req0_page, req0_col, req0_data})
                           : wr_t'({req1_page, req1_col, req1_data});
                    grants.push_back(e0 ? 0 : 1);
                    last_idle_len = idle_len;
                    model_write(w);
                    mptr = e0;
                end
            end else begin
                chk("ready_busy", 32'({req1_ready, req0_ready}), 0);
                idle_len = 0;
            end
            if (lcd_en && !pen) begin
                chk("setup_stable", 32'(snap), 32'(psnap));
                cur_txn = snap;
                en_len = 1;
            end else if (lcd_en) begin
                chk("en_stable", 32'(snap), 32'(cur_txn));
                en_len++;
            end else if (pen) begin
                chk("en_width", en_len, EN_CYC);
                chk("hold_stable", 32'(snap), 32'(cur_txn));
                hold_left = EN_CYC - 1;
                obs.push_back(cur_txn);
                chk("txn_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("txn", 32'(cur_txn), 32'(exp_q.pop_front()));
            end else if (hold_left > 0) begin
                chk("hold_stable", 32'(snap), 32'(cur_txn));
                hold_left--;
            end
            pen   = lcd_en;
            psnap = snap;
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid &&
                 !busy && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 1);
    endtask

    task automatic chk_obs(input string name, input int idx, input logic [10:0] expv);
        if (idx < obs.size()) chk(name, 32'(obs[idx]), 32'(expv));
        else chk({name, "_missing"}, idx, 32'(obs.size()));
    endtask

    int base, g, r0;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(lcd_data), 0);
        chk("rst_ctl", 32'({lcd_en, lcd_rw, lcd_di, lcd_cs1, lcd_cs2, lcd_rstn}), 0);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 0);
        chk("rst_busy", 32'(busy), 1);

        // Release just after an edge so each sampled low cycle is a full clock.
        @(posedge clk); #1 rst_n = 1'b1;
        base = obs.size();
        wait_idle(3000);
        chk("rstn_low_cycles", rstn_low, RST_CYC);
        chk("init_count", obs.size() - base, 2);
        chk_obs("init_on", base, {8'h3F, 1'b0, 2'b11});
        chk_obs("init_line", base + 1, {8'hC0, 1'b0, 2'b11});

        // req0 page 2 col 10: full address set-up on cs1.
        base = obs.size(); g = grants.size(); r0 = r0_cnt;
        q0.push_back('{3'd2, 7'd10, 8'hA5});
        wait_idle(2000);
        chk("wr1_count", obs.size() - base, 3);
        chk_obs("wr1_page", base, {8'hBA, 1'b0, 2'b01});
        chk_obs("wr1_col", base + 1, {8'h4A, 1'b0, 2'b01});
        chk_obs("wr1_data", base + 2, {8'hA5, 1'b1, 2'b01});
        chk("wr1_ready_pulses", r0_cnt - r0, 1);

        // Next column on the same page: data only.
        base = obs.size();
        q0.push_back('{3'd2, 7'd11, 8'h5A});
        wait_idle(2000);
        chk("wr2_count", obs.size() - base, 1);
        chk_obs("wr2_data", base, {8'h5A, 1'b1, 2'b01});

        // req1 write on chip 2 brings the pointer back to req0.
        base = obs.size();
        q1.push_back('{3'd4, 7'd100, 8'h77});
        wait_idle(2000);
        chk("wr3_count", obs.size() - base, 3);
        chk_obs("wr3_page", base, {8'hBC, 1'b0, 2'b10});
        chk_obs("wr3_col", base + 1, {8'h64, 1'b0, 2'b10});
        chk_obs("wr3_data", base + 2, {8'h77, 1'b1, 2'b10});

        // Simultaneous requests: req0, then req1, then req0 again.
        g = grants.size();
        q0.push_back('{3'd3, 7'd5, 8'h11});
        q0.push_back('{3'd3, 7'd7, 8'h33});
        q1.push_back('{3'd3, 7'd6, 8'h22});
        wait_idle(4000);
        chk("rr_grants", grants.size() - g, 3);
        if (grants.size() >= g + 3) begin
            chk("rr_first", grants[g], 0);
            chk("rr_second", grants[g+1], 1);
            chk("rr_third", grants[g+2], 0);
        end

        // Chip boundary: col 63 then col 64 re-addresses on cs2 only.
        base = obs.size();
        q0.push_back('{3'd5, 7'd63, 8'hC1});
        q0.push_back('{3'd5, 7'd64, 8'hC2});
        wait_idle(4000);
        chk("chip_count", obs.size() - base, 6);
        chk_obs("chip_c1_col", base + 1, {8'h7F, 1'b0, 2'b01});
        chk_obs("chip_c2_page", base + 3, {8'hBD, 1'b0, 2'b10});
        chk_obs("chip_c2_col", base + 4, {8'h40, 1'b0, 2'b10});
        chk_obs("chip_c2_data", base + 5, {8'hC2, 1'b1, 2'b10});

        // Y wrap: col 63 then col 0 on the same page skips addressing; back-to-back grant.
        base = obs.size();
        q0.push_back('{3'd5, 7'd63, 8'hD1});
        q0.push_back('{3'd5, 7'd0, 8'hD2});
        wait_idle(4000);
        chk("wrap_count", obs.size() - base, 4);
        chk_obs("wrap_data", base + 3, {8'hD2, 1'b1, 2'b01});
        chk("b2b_idle_cycles", last_idle_len, 1);

        // Reset while the data strobe is high.
        q0.push_back('{3'd6, 7'd20, 8'hE7});
        begin
            int n = 0;
            @(negedge clk);
            while (!(lcd_en && lcd_di) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("wr_data_seen", 32'(n < 2000), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(lcd_en), 0);
        chk("midrst_busy", 32'(busy), 1);
        chk("midrst_rstn", 32'(lcd_rstn), 0);
        chk("midrst_cs", 32'({lcd_cs2, lcd_cs1}), 0);
        repeat (2) @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        base = obs.size();
        wait_idle(3000);
        chk("reinit_rstn_low", rstn_low, RST_CYC);
        chk("reinit_count", obs.size() - base, 2);
        chk_obs("reinit_on", base, {8'h3F, 1'b0, 2'b11});
        chk_obs("reinit_line", base + 1, {8'hC0, 1'b0, 2'b11});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/lcd_write_scheduler.md
LCD_WRITE_SCHEDULER -- requirements
Module: lcd_write_scheduler

Interface
REQ-001 Parameter EN_CYC, default 4: clock cycles lcd_en is held high, and also held low after each bus transaction.
REQ-002 Parameter RST_CYC, default 16: clock cycles lcd_rstn is held low after reset release.
REQ-003 clk  input  1  sole clock; all logic rises on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester n holds a pixel-byte write.
REQ-006 req0_page / req1_page  input  3  target page 0-7.
REQ-007 req0_col / req1_col  input  7  target column 0-127; bit 6 selects the chip.
REQ-008 req0_data / req1_data  input  8  display byte.
REQ-009 req0_ready / req1_ready  output  1  one-cycle accept pulse; a transfer occurs when valid and ready are both high.
REQ-010 busy  output  1  high during init or while a write is in progress.
REQ-011 lcd_data  output  8  LCD bus data.
REQ-012 lcd_en, lcd_rw, lcd_di  output  1 each  LCD strobe, read/write select and data/instruction select.
REQ-013 lcd_rstn  output  1  LCD reset, active low.
REQ-014 lcd_cs1, lcd_cs2  output  1 each  chip selects: cs1 for columns 0-63, cs2 for columns 64-127.

Function
REQ-015 Every LCD bus transaction SHALL follow this sequence:
  - 1 setup cycle with data, di and cs stable and lcd_en=0;
  - EN_CYC cycles with lcd_en=1;
  - EN_CYC cycles with lcd_en=0 and data, di and cs held.
  Total length is 1+2*EN_CYC cycles.
REQ-016 lcd_rw SHALL be 0 at all times.
REQ-017 Command transactions SHALL drive di=0; data transactions SHALL drive di=1.
REQ-018 FSM states: RST_HOLD, INIT_ON, INIT_LINE, IDLE, SET_PAGE, SET_COL, WR_DATA.
REQ-019 RST_HOLD:
  - lcd_rstn=0 for RST_CYC cycles, then 1;
  - then wait RST_CYC further cycles;
  - then go to INIT_ON.
REQ-020 INIT_ON SHALL issue command 0x3F (display on) with cs1=cs2=1, then go to INIT_LINE.
REQ-021 INIT_LINE SHALL issue command 0xC0 (start line 0) with cs1=cs2=1, then go to IDLE.
REQ-022 In IDLE, busy=0 and arbitration is evaluated every cycle.
REQ-023 Arbitration is round-robin with a pointer that resets to 0:
  - if both valids are high, the pointer's requester wins;
  - if one valid is high, that requester wins;
  - the pointer toggles to the other requester after every grant.
REQ-024 On a grant, the winner's ready SHALL pulse for exactly one cycle and page, col and data SHALL be latched that cycle.
REQ-025 The FSM leaves IDLE on the cycle after a grant, and busy=1 from that cycle onward.
REQ-026 ready SHALL never be asserted outside IDLE, and never for both requesters in the same cycle.
REQ-027 Address cache: registers cache_vld, cache_chip, cache_page, cache_y(6 bits).
REQ-028 Next state after a grant:
  - WR_DATA if cache_vld, cache_chip==col[6], cache_page==page and cache_y==col[5:0];
  - otherwise SET_PAGE.
REQ-029 SET_PAGE SHALL issue command 0xB8|page on the selected chip, then go to SET_COL.
REQ-030 SET_COL SHALL issue command 0x40|col[5:0] on the selected chip, then go to WR_DATA.
REQ-031 WR_DATA SHALL issue the data byte on the selected chip, then return to IDLE.
REQ-032 After WR_DATA, the cache SHALL be updated:
  - cache_vld=1;
  - chip and page = the latched values;
  - cache_y = col[5:0]+1, wrapping 63->0 to match the panel's auto-increment.
REQ-033 Only the selected chip's cs is high during SET_PAGE, SET_COL and WR_DATA; both cs are 0 in IDLE.
REQ-034 Back-to-back: a request held valid during WR_DATA is granted on the first IDLE cycle, so there is exactly one IDLE cycle between transactions.

Reset
REQ-035 Asserting rst_n=0 SHALL take effect immediately, including mid-transaction; no partial transaction resumes.
REQ-036 Values while reset is asserted:
  - lcd_data=0, lcd_en=0, lcd_rw=0, lcd_di=0, lcd_cs1=0, lcd_cs2=0, lcd_rstn=0;
  - req0_ready=0, req1_ready=0, busy=1;
  - FSM=RST_HOLD, pointer=0, cache_vld=0, counters=0.

Structure
REQ-037 A shared package SHALL hold:
  - the FSM state encoding;
  - command constants CMD_ON=0x3F, CMD_LINE=0xC0, CMD_PAGE=0xB8, CMD_Y=0x40.
REQ-038 One sub-module, lcd_bus_cycle, SHALL own the REQ-015 timing.
  - Inputs: start, data, di, cs.
  - Output: done, a one-cycle pulse at the end of the transaction.
  - The FSM advances only on done.

Verification
REQ-039 Reset release with EN_CYC=4, RST_CYC=16:
  - lcd_rstn=0 for 16 cycles;
  - then 0x3F on cs1+cs2, then 0xC0 on cs1+cs2, each with en high for exactly 4 cycles;
  - busy falls after the second transaction.
REQ-040 req0 write (page 2, col 10, 0xA5):
  - bus shows 0xBA (cs1), 0x4A (cs1), then 0xA5 (cs1, di=1);
  - req0_ready pulses once.
REQ-041 A follow-up req0 write (page 2, col 11, 0x5A) SHALL produce only the data transaction 0x5A with no address commands.
REQ-042 req0 and req1 valid in the same cycle, pointer=0:
  - req0 is granted first, then req1;
  - on a third simultaneous request, req0 is granted again only after req1.
REQ-043 Chip boundary and wrap:
  - write to col 63 then col 64: the second write issues fresh address commands on cs2 only;
  - a write to col 63 followed by col 0 on the same page SHALL skip the address commands (cache wrap).
REQ-044 Reset mid-operation: rst_n=0 during lcd_en high in WR_DATA SHALL force lcd_en=0 and busy=1 immediately; the full init sequence repeats after release.
